pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Parametrised pipeline control unit for the 5-stage 16-bit core.
- Replaces the fixed hazard unit and the ad-hoc stop flag with a single block that provides:
  - forwarding selects, load-use stall, branch/jump flush;
  - a wait-state handshake to a variable-latency data memory;
  - a run/drain/halt/error state machine;
  - saturating performance counters.
- Sits beside the pipeline stages and drives every stage's stall/flush input.

Parameters:
- REG_WIDTH, 4, register index width.
- STAGES, 5, pipeline depth; drain length is STAGES-2 cycles.
- ZERO_REG_HARDWIRED, 0, 1 = register 0 never forwards or causes a hazard.
- MEM_TIMEOUT, 16, consecutive wait cycles before ERROR (2..255).
- CNT_WIDTH, 16, performance counter width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, leave IDLE/HALTED and run.
- stop_req, in, 1, halt instruction decoded in ID.
- rs_d, rt_d, in, REG_WIDTH each, ID source registers.
- uses_rs_d, uses_rt_d, in, 1 each, ID instruction reads rs/rt.
- jump_d, in, 1, jump in ID.
- rs_e, rt_e, in, REG_WIDTH each, EX source registers.
- mem_read_e, in, 1, EX instruction is a load.
- write_reg_e, in, REG_WIDTH, EX destination register.
- reg_write_m, in, 1, MEM writeback enable.
- write_reg_m, in, REG_WIDTH, MEM destination register.
- branch_taken_m, in, 1, branch resolved taken in MEM.
- reg_write_w, in, 1, WB writeback enable.
- write_reg_w, in, REG_WIDTH, WB destination register.
- dm_req, in, 1, MEM stage accessing data memory.
- dm_ready, in, 1, data memory completes this cycle.
- fwd_a_e, fwd_b_e, out, 2 each, EX operand select: 00 register file, 01 MEM result, 10 WB result.
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, out, 1 each, hold register.
- flush_if_id, flush_id_ex, flush_ex_mem, out, 1 each, insert bubble.
- pc_reset, out, 1, one-cycle pulse to reload PC to 0.
- run, out, 1, state is RUN or DRAIN.
- stop, out, 1, state is HALTED or ERROR (registered).
- err, out, 1, memory timeout (sticky).
- cyc_cnt, stall_cnt, flush_cnt, out, CNT_WIDTH each, performance counters.

Behaviour:
- **States:** IDLE, RUN, DRAIN, HALTED, ERROR.
- **Reset:** state=IDLE; stop=0; err=0; pc_reset=0; counters=0; drain and wait counters=0.
- **IDLE/HALTED/ERROR outputs:** all stall_*=1; flushes=0; fwd=00; run=0.
- **Start:** start in IDLE or HALTED → RUN next cycle, with pc_reset=1 and all counters cleared in that transition cycle. start is ignored in RUN, DRAIN and ERROR.
- **Forwarding** (combinational, RUN/DRAIN):
  - fwd_a_e=01 if reg_write_m && write_reg_m==rs_e.
  - else 10 if reg_write_w && write_reg_w==rs_e.
  - else 00.
  - fwd_b_e is identical using rt_e.
  - With ZERO_REG_HARDWIRED=1, register 0 never matches.
- **Priority per cycle** in RUN/DRAIN (highest first):
  1. Memory wait (dm_req && !dm_ready): all five stall_*=1, no flushes, no state change except wait counting.
  2. branch_taken_m: flush_if_id = flush_id_ex = flush_ex_mem = 1; flush_cnt++.
  3. Load-use (mem_read_e && write_reg_e matches rs_d with uses_rs_d, or rt_d with uses_rt_d): stall_pc = stall_if_id = 1, flush_id_ex=1; stall_cnt++.
  4. jump_d: flush_if_id=1.
  5. stop_req (RUN only): enter DRAIN.
  - A lower-priority event is suppressed in a cycle where a higher one applies; stop_req suppressed by load-use is simply re-presented next cycle.
- **Wait counter:**
  - Increments on each wait cycle; cleared on any non-wait cycle; stall_cnt++ per wait cycle.
  - Reaching MEM_TIMEOUT → ERROR next cycle; err=1 and stop=1 until rst.
- **DRAIN:**
  - Drain counter is loaded with STAGES-2 on entry.
  - Each cycle: stall_pc=1, flush_if_id=1.
  - Counter decrements only on non-wait cycles; HALTED on the cycle after it reaches 0.
  - branch_taken_m during DRAIN (older branch squashes the halt) → back to RUN, branch flush applied, stall_pc released next cycle.
- **HALTED:** stop=1 the cycle after entry.
- **Counters:**
  - cyc_cnt increments every RUN/DRAIN cycle.
  - All counters saturate at 2^CNT_WIDTH-1.
- **Reset mid-operation:** rst dominates everything, including ERROR and active stalls.

Test Plan:
- rst, then start=1 one cycle → pc_reset=1 that cycle; run=1 next; all stall_*=0; cyc_cnt=1 after the first RUN cycle.
- reg_write_m=1, write_reg_m=3, reg_write_w=1, write_reg_w=3, rs_e=3, rt_e=5 → fwd_a_e=01, fwd_b_e=00. With write_reg_m=0, ZERO_REG_HARDWIRED=1, rs_e=0 → fwd_a_e=00.
- mem_read_e=1, write_reg_e=4, rt_d=4, uses_rt_d=1, stop_req=1 same cycle → stall_pc=1, flush_id_ex=1, state stays RUN, stall_cnt=1. Next cycle without hazard → DRAIN.
- stop_req in RUN → exactly 3 DRAIN cycles (STAGES=5), then HALTED, stop=1. Repeat with dm_req=1, dm_ready=0 for 2 cycles mid-drain → 5 DRAIN cycles.
- Enter DRAIN, branch_taken_m=1 in first DRAIN cycle → all three flushes =1, flush_cnt=1, state RUN, stop stays 0.
- dm_req=1, dm_ready=0 held 16 cycles → all stalls =1 throughout, ERROR, err=1, stop=1. start ignored; rst → IDLE, err=0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipeline control for the 5-stage 16-bit core.
// Provides EX operand forwarding, load-use stall, branch/jump flush,
// data-memory wait-state stalling with timeout, the run/drain/halt/error
// sequencer and saturating performance counters.
module pipe_ctrl_unit #(
  parameter int REG_WIDTH          = 4,
  parameter int STAGES             = 5,
  parameter bit ZERO_REG_HARDWIRED = 1'b0,
  parameter int MEM_TIMEOUT        = 16,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop_req,
  input  logic [REG_WIDTH-1:0] rs_d,
  input  logic [REG_WIDTH-1:0] rt_d,
  input  logic                 uses_rs_d,
  input  logic                 uses_rt_d,
  input  logic                 jump_d,
  input  logic [REG_WIDTH-1:0] rs_e,
  input  logic [REG_WIDTH-1:0] rt_e,
  input  logic                 mem_read_e,
  input  logic [REG_WIDTH-1:0] write_reg_e,
  input  logic                 reg_write_m,
  input  logic [REG_WIDTH-1:0] write_reg_m,
  input  logic                 branch_taken_m,
  input  logic                 reg_write_w,
  input  logic [REG_WIDTH-1:0] write_reg_w,
  input  logic                 dm_req,
  input  logic                 dm_ready,
  output logic [1:0]           fwd_a_e,
  output logic [1:0]           fwd_b_e,
  output logic                 stall_pc,
  output logic                 stall_if_id,
  output logic                 stall_id_ex,
  output logic                 stall_ex_mem,
  output logic                 stall_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 pc_reset,
  output logic                 run,
  output logic                 stop,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] cyc_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_ERROR
  } state_e;

  localparam logic [7:0] DRAIN_LOAD   = 8'(STAGES - 2);
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic                 stop_q, stop_d;
  logic                 err_q, err_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic [7:0]           drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic active;
  logic mem_wait;
  logic load_use;

  // Register-index compare; register 0 is excluded when it is hardwired.
  function automatic logic reg_match(input logic [REG_WIDTH-1:0] a,
                                     input logic [REG_WIDTH-1:0] b);
    return (a == b) && !(ZERO_REG_HARDWIRED && (a == '0));
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Hazard and wait-state conditions derived from the current pipeline contents.
  always_comb begin
    active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    mem_wait = dm_req && !dm_ready;
    load_use = mem_read_e &&
               ((uses_rs_d && reg_match(write_reg_e, rs_d)) ||
                (uses_rt_d && reg_match(write_reg_e, rt_d)));
  end

  // EX operand forwarding: the MEM result is newer than WB, so it wins.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (active && !rst) begin
      if (reg_write_m && reg_match(write_reg_m, rs_e))      fwd_a_e = 2'b01;
      else if (reg_write_w && reg_match(write_reg_w, rs_e)) fwd_a_e = 2'b10;
      if (reg_write_m && reg_match(write_reg_m, rt_e))      fwd_b_e = 2'b01;
      else if (reg_write_w && reg_match(write_reg_w, rt_e)) fwd_b_e = 2'b10;
    end
  end

  // Sequencer next state, per-cycle stall/flush decisions and counter updates.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    stall_pc     = 1'b1;
    stall_if_id  = 1'b1;
    stall_id_ex  = 1'b1;
    stall_ex_mem = 1'b1;
    stall_mem_wb = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pc_reset     = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d     = S_RUN;
          pc_reset    = 1'b1;
          wait_cnt_d  = '0;
          drain_cnt_d = '0;
          cyc_cnt_d   = '0;
          stall_cnt_d = '0;
          flush_cnt_d = '0;
        end
      end
      S_RUN, S_DRAIN: begin
        stall_pc     = (state_q == S_DRAIN);
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_if_id  = (state_q == S_DRAIN);
        cyc_cnt_d    = sat_inc(cyc_cnt_q);
        if (mem_wait) begin
          // Freeze the whole pipe; only the wait bookkeeping moves.
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
          stall_mem_wb = 1'b1;
          flush_if_id  = 1'b0;
          stall_cnt_d  = sat_inc(stall_cnt_q);
          wait_cnt_d   = wait_cnt_q + 8'd1;
          if (wait_cnt_q >= TIMEOUT_LAST) state_d = S_ERROR;
        end else begin
          wait_cnt_d = '0;
          if (state_q == S_DRAIN) begin
            if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - 8'd1;
            if (drain_cnt_q <= 8'd1) state_d = S_HALTED;
          end
          if (branch_taken_m) begin
            // An older taken branch squashes younger work, including a pending halt.
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_cnt_d  = sat_inc(flush_cnt_q);
            state_d      = S_RUN;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
          end else if (jump_d) begin
            flush_if_id = 1'b1;
          end else if (stop_req && (state_q == S_RUN)) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase

    stop_d = (state_d == S_HALTED) || (state_d == S_ERROR);
    err_d  = err_q || (state_d == S_ERROR);

    // Reset overrides any stall/flush decision from a stale state.
    if (rst) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      stall_mem_wb = 1'b1;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      pc_reset     = 1'b0;
    end
  end

  // State, status and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      stop_q      <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stop_q      <= stop_d;
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign run       = active;
  assign stop      = stop_q;
  assign err       = err_q;
  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed bench for pipe_ctrl_unit with register 0
// hardwired and 4-bit counters so saturation is reachable quickly.
module tb_pipe_ctrl_unit;

  localparam int RW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, stop_req;
  logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic          uses_rs_d, uses_rt_d, jump_d, mem_read_e, reg_write_m;
  logic          branch_taken_m, reg_write_w, dm_req, dm_ready;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic          flush_if_id, flush_id_ex, flush_ex_mem;
  logic          pc_reset, run, stop, err;
  logic [CW-1:0] cyc_cnt, stall_cnt, flush_cnt;

  logic [4:0] stalls;
  logic [2:0] flushes;
  int checks = 0;
  int errors = 0;

  assign stalls  = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb};
  assign flushes = {flush_if_id, flush_id_ex, flush_ex_mem};

  pipe_ctrl_unit #(
    .REG_WIDTH(RW), .STAGES(5), .ZERO_REG_HARDWIRED(1'b1),
    .MEM_TIMEOUT(16), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .jump_d(jump_d), .rs_e(rs_e), .rt_e(rt_e), .mem_read_e(mem_read_e),
    .write_reg_e(write_reg_e), .reg_write_m(reg_write_m), .write_reg_m(write_reg_m),
    .branch_taken_m(branch_taken_m), .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
    .dm_req(dm_req), .dm_ready(dm_ready), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pc_reset(pc_reset), .run(run), .stop(stop), .err(err),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stop_req = 0; rs_d = 0; rt_d = 0; uses_rs_d = 0; uses_rt_d = 0; jump_d = 0;
    rs_e = 0; rt_e = 0; mem_read_e = 0; write_reg_e = 0; reg_write_m = 0;
    write_reg_m = 0; branch_taken_m = 0; reg_write_w = 0; write_reg_w = 0;
    dm_req = 0; dm_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; clear_inputs();
    tick(); tick();
    rst = 0; #1;
    check("idle_stalls", 32'(stalls), 32'h1f);
    check("idle_flushes", 32'(flushes), 32'h0);
    check("idle_run", 32'(run), 32'h0);
    check("idle_stop", 32'(stop), 32'h0);
    check("idle_err", 32'(err), 32'h0);
    check("idle_pc_reset", 32'(pc_reset), 32'h0);
    check("idle_cyc", 32'(cyc_cnt), 32'h0);
    reg_write_m = 1; write_reg_m = 3; rs_e = 3; #1;
    check("idle_fwd_a", 32'(fwd_a_e), 32'h0);
    clear_inputs();

    // Start: pc_reset during the transition cycle, RUN afterwards.
    start = 1; #1;
    check("start_pc_reset", 32'(pc_reset), 32'h1);
    tick(); start = 0; #1;
    check("run_after_start", 32'(run), 32'h1);
    check("run_stalls", 32'(stalls), 32'h0);
    check("run_pc_reset_low", 32'(pc_reset), 32'h0);
    check("cyc_cleared", 32'(cyc_cnt), 32'h0);
    tick();
    check("cyc_first", 32'(cyc_cnt), 32'h1);

    // Forwarding patterns.
    reg_write_m = 1; write_reg_m = 3; reg_write_w = 1; write_reg_w = 3; rs_e = 3; rt_e = 5; #1;
    check("fwd_a_mem", 32'(fwd_a_e), 32'h1);
    check("fwd_b_none", 32'(fwd_b_e), 32'h0);
    write_reg_m = 7; rt_e = 3; #1;
    check("fwd_a_wb", 32'(fwd_a_e), 32'h2);
    check("fwd_b_wb", 32'(fwd_b_e), 32'h2);
    reg_write_m = 0; write_reg_m = 3; #1;
    check("fwd_a_m_disabled", 32'(fwd_a_e), 32'h2);
    reg_write_m = 1; write_reg_m = 0; reg_write_w = 0; rs_e = 0; #1;
    check("fwd_a_zero_m", 32'(fwd_a_e), 32'h0);
    reg_write_m = 0; reg_write_w = 1; write_reg_w = 0; #1;
    check("fwd_a_zero_w", 32'(fwd_a_e), 32'h0);
    clear_inputs();
    tick();

    // Ready memory, zero-register load, rs load-use, use-flag gating.
    dm_req = 1; dm_ready = 1; #1;
    check("mem_ready_no_stall", 32'(stalls), 32'h0);
    dm_req = 0; dm_ready = 0;
    mem_read_e = 1; write_reg_e = 0; rs_d = 0; uses_rs_d = 1; #1;
    check("lu_zero_reg", 32'(stalls), 32'h0);
    write_reg_e = 6; rs_d = 6; #1;
    check("lu_rs_stalls", 32'(stalls), 32'h18);
    uses_rs_d = 0; #1;
    check("lu_rs_unused", 32'(stalls), 32'h0);
    clear_inputs();
    tick();

    // Load-use suppresses stop_req; stop_req re-presented enters DRAIN.
    mem_read_e = 1; write_reg_e = 4; rt_d = 4; uses_rt_d = 1; stop_req = 1; #1;
    check("lu_stop_stalls", 32'(stalls), 32'h18);
    check("lu_stop_flushes", 32'(flushes), 32'h2);
    tick();
    mem_read_e = 0; uses_rt_d = 0; #1;
    check("lu_stall_cnt", 32'(stall_cnt), 32'h1);
    check("still_run_stalls", 32'(stalls), 32'h0);
    tick(); stop_req = 0; #1;
    check("drain1_stalls", 32'(stalls), 32'h10);
    check("drain1_flushes", 32'(flushes), 32'h4);
    check("drain1_cyc", 32'(cyc_cnt), 32'h5);
    tick();
    check("drain2_run", 32'(run), 32'h1);
    tick();
    check("drain3_run", 32'(run), 32'h1);
    check("drain3_stop", 32'(stop), 32'h0);
    tick();
    check("halted_run", 32'(run), 32'h0);
    check("halted_stop", 32'(stop), 32'h1);
    check("halted_stalls", 32'(stalls), 32'h1f);
    check("halted_cyc", 32'(cyc_cnt), 32'h8);

    // Drain with two memory wait cycles lasts five cycles.
    start = 1; #1;
    check("restart_pc_reset", 32'(pc_reset), 32'h1);
    tick(); start = 0;
    check("restart_stop_low", 32'(stop), 32'h0);
    stop_req = 1; tick(); stop_req = 0;
    tick();
    dm_req = 1; dm_ready = 0; #1;
    check("drain_wait_stalls", 32'(stalls), 32'h1f);
    check("drain_wait_flushes", 32'(flushes), 32'h0);
    tick(); tick();
    dm_req = 0; #1;
    check("drain_after_wait", 32'(stalls), 32'h10);
    tick();
    check("drain5_run", 32'(run), 32'h1);
    tick();
    check("wdrain_halted_run", 32'(run), 32'h0);
    check("wdrain_halted_stop", 32'(stop), 32'h1);
    check("wdrain_stall_cnt", 32'(stall_cnt), 32'h2);
    check("wdrain_cyc", 32'(cyc_cnt), 32'h6);

    // Taken branch in the first drain cycle returns to RUN.
    start = 1; tick(); start = 0;
    stop_req = 1; tick(); stop_req = 0;
    branch_taken_m = 1; #1;
    check("drain_br_flushes", 32'(flushes), 32'h7);
    check("drain_br_stalls", 32'(stalls), 32'h10);
    tick(); branch_taken_m = 0; #1;
    check("br_back_run", 32'(run), 32'h1);
    check("br_back_stalls", 32'(stalls), 32'h0);
    check("br_back_stop", 32'(stop), 32'h0);
    check("br_flush_cnt", 32'(flush_cnt), 32'h1);

    // Jump alone; branch suppresses a simultaneous load-use.
    jump_d = 1; #1;
    check("jump_flushes", 32'(flushes), 32'h4);
    check("jump_stalls", 32'(stalls), 32'h0);
    jump_d = 0;
    branch_taken_m = 1; mem_read_e = 1; write_reg_e = 2; rs_d = 2; uses_rs_d = 1; #1;
    check("br_lu_flushes", 32'(flushes), 32'h7);
    check("br_lu_stalls", 32'(stalls), 32'h0);
    tick(); clear_inputs(); #1;
    check("br_lu_flush_cnt", 32'(flush_cnt), 32'h2);
    check("br_lu_stall_cnt", 32'(stall_cnt), 32'h0);

    // Cycle counter saturates.
    repeat (20) tick();
    check("cyc_saturated", 32'(cyc_cnt), 32'hf);

    // Memory timeout after 16 wait cycles.
    dm_req = 1; dm_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("timeout_stalls", 32'(stalls), 32'h1f);
      if (i == 15) begin
        check("timeout_last_run", 32'(run), 32'h1);
        check("timeout_last_err", 32'(err), 32'h0);
      end
      tick();
    end
    check("error_run", 32'(run), 32'h0);
    check("error_err", 32'(err), 32'h1);
    check("error_stop", 32'(stop), 32'h1);
    check("error_stall_cnt_sat", 32'(stall_cnt), 32'hf);
    dm_req = 0; start = 1; #1;
    check("error_start_no_pc_reset", 32'(pc_reset), 32'h0);
    check("error_stalls", 32'(stalls), 32'h1f);
    tick(); start = 0; #1;
    check("error_start_ignored_run", 32'(run), 32'h0);
    check("error_sticky", 32'(err), 32'h1);

    // Reset clears ERROR.
    rst = 1; tick(); rst = 0; #1;
    check("rst_err", 32'(err), 32'h0);
    check("rst_stop", 32'(stop), 32'h0);
    check("rst_run", 32'(run), 32'h0);
    check("rst_stalls", 32'(stalls), 32'h1f);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
